ldpc_serial_seq: RTL

LDPC_SERIAL_SEQ -- requirements
Module: ldpc_serial_seq

---
 rtl/ldpc_serial_seq.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/ldpc_serial_seq.sv
// Wishbone-controlled serial sequencer for an LDPC codec: shifts TXDATA out, waits for the codec
// latency, then shifts RXDATA in. Optional done interrupt is built when LDPC_SEQ_IRQ_EN is defined.
module ldpc_serial_seq (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        P_inputnoutput,
    output logic        P_input,
    output logic [15:0] P_in_out_sel,
    input  logic        PO_output,
    output logic        seq_irq_o
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StShift = 3'd1,
        StWait  = 3'd2,
        StRead  = 3'd3,
        StDone  = 3'd4
    } state_e;

    state_e      state_q;
    logic        ack_q;
    logic [31:0] dat_q;
    logic [31:0] cfg_q, cfg_d;
    logic [31:0] tx_q, tx_d;
    logic [31:0] rx_q;
    logic [31:0] shift_q;
    logic [4:0]  bit_cnt_q;
    logic [7:0]  wait_cnt_q;
    logic        start_q;
    logic        done_q;
    logic        pin_q;
    logic        dir_q;
    logic        irq_en;

    logic        req, wr, busy_st, busy;
    logic        ctrl_wr, cfg_wr, tx_wr;
    logic        start_req, clr_req, abort_req;
    logic [4:0]  cfg_len;
    logic [7:0]  cfg_wait;
    logic [31:0] rdata;
    logic        unused_adr;

    assign unused_adr = ^{wbs_adr_i[31:4], wbs_adr_i[1:0]};

    assign cfg_len  = cfg_q[20:16];
    assign cfg_wait = cfg_q[31:24];

    // A new request is only taken when no ack is outstanding, so each cyc&stb gets one ack.
    assign req       = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign wr        = req & wbs_we_i;
    assign busy_st   = (state_q != StIdle);
    assign busy      = busy_st | start_q;
    assign ctrl_wr   = wr & (wbs_adr_i[3:2] == 2'd0) & wbs_sel_i[0];
    assign cfg_wr    = wr & (wbs_adr_i[3:2] == 2'd1) & ~busy;
    assign tx_wr     = wr & (wbs_adr_i[3:2] == 2'd2) & ~busy;
    assign start_req = ctrl_wr & wbs_dat_i[0];
    assign clr_req   = ctrl_wr & wbs_dat_i[1];
    assign abort_req = ctrl_wr & wbs_dat_i[2];

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

    assign cfg_d = byte_merge(cfg_q, wbs_dat_i, wbs_sel_i);
    assign tx_d  = byte_merge(tx_q, wbs_dat_i, wbs_sel_i);

    always_comb begin
        rdata = '0;
        unique case (wbs_adr_i[3:2])
            2'd0: rdata[7:0] = {1'b0, state_q, irq_en, 1'b0, done_q, busy_st};
            2'd1: rdata = cfg_q;
            2'd2: rdata = tx_q;
            2'd3: rdata = rx_q;
        endcase
    end

    // Bus side: ack, read data, configuration and the start request pulse.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q   <= 1'b0;
            dat_q   <= '0;
            cfg_q   <= '0;
            tx_q    <= '0;
            start_q <= 1'b0;
        end else begin
            ack_q <= req;
            if (req) dat_q <= rdata;
            if (cfg_wr) cfg_q <= cfg_d;
            if (tx_wr) tx_q <= tx_d;
            if (abort_req) begin
                start_q <= 1'b0;
            end else if (start_req && !busy) begin
                start_q <= 1'b1;
            end else begin
                start_q <= 1'b0;
            end
        end
    end

`ifdef LDPC_SEQ_IRQ_EN
    logic irq_en_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            irq_en_q <= 1'b0;
        end else if (ctrl_wr) begin
            irq_en_q <= wbs_dat_i[3];
        end
    end

    assign irq_en    = irq_en_q;
    assign seq_irq_o = done_q & irq_en_q;
`else
    assign irq_en    = 1'b0;
    assign seq_irq_o = 1'b0;
`endif

    // Sequencer: shift out, codec latency, shift in, one-cycle done.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            rx_q       <= '0;
            bit_cnt_q  <= '0;
            wait_cnt_q <= '0;
            done_q     <= 1'b0;
            pin_q      <= 1'b0;
            dir_q      <= 1'b0;
        end else begin
            if (clr_req) done_q <= 1'b0;
            if (abort_req && busy_st) begin
                state_q    <= StIdle;
                dir_q      <= 1'b0;
                pin_q      <= 1'b0;
                bit_cnt_q  <= '0;
                wait_cnt_q <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start_q) begin
                            state_q   <= StShift;
                            // Bit 0 goes straight to the pin; the register keeps what is left.
                            shift_q   <= {1'b0, tx_q[31:1]};
                            pin_q     <= tx_q[0];
                            dir_q     <= 1'b1;
                            rx_q      <= '0;
                            done_q    <= 1'b0;
                            bit_cnt_q <= '0;
                        end
                    end
                    StShift: begin
                        shift_q <= {1'b0, shift_q[31:1]};
                        if (bit_cnt_q == cfg_len) begin
                            bit_cnt_q  <= '0;
                            wait_cnt_q <= '0;
                            dir_q      <= 1'b0;
                            pin_q      <= 1'b0;
                            state_q    <= (cfg_wait == 8'd0) ? StRead : StWait;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                            pin_q     <= shift_q[0];
                        end
                    end
                    StWait: begin
                        if (wait_cnt_q == cfg_wait - 8'd1) begin
                            state_q <= StRead;
                        end else begin
                            wait_cnt_q <= wait_cnt_q + 8'd1;
                        end
                    end
                    StRead: begin
                        rx_q[bit_cnt_q] <= PO_output;
                        if (bit_cnt_q == cfg_len) begin
                            state_q <= StDone;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign wbs_ack_o      = ack_q;
    assign wbs_dat_o      = dat_q;
    assign P_inputnoutput = dir_q;
    assign P_input        = pin_q;
    assign P_in_out_sel   = cfg_q[15:0];

endmodule
